// File: rtl/xcorr_peak_finder_if.sv
// Stream bundle between the cross-spectrum multiplier, the peak finder and the TDOA logic.
// The slave modport is the peak finder's view; the master modport is the surrounding logic's view.
// Neighbour ports exist only when XCORR_PEAK_NEIGHBOURS_EN is defined.
interface xcorr_peak_finder_if #(
  parameter int DATA_W = 47,
  parameter int BIN_W  = 10
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_peak_value;
  logic [BIN_W-1:0]  m_peak_bin;
  logic              m_no_peak;
  logic              m_len_err;
`ifdef XCORR_PEAK_NEIGHBOURS_EN
  logic [DATA_W-1:0] m_left_value;
  logic [DATA_W-1:0] m_right_value;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_peak_value, m_peak_bin, m_no_peak, m_len_err,
    output m_left_value, m_right_value
  );
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_peak_value, m_peak_bin, m_no_peak, m_len_err,
    input  m_left_value, m_right_value
  );
`else
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_peak_value, m_peak_bin, m_no_peak, m_len_err
  );
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_peak_value, m_peak_bin, m_no_peak, m_len_err
  );
`endif
endinterface

// File: rtl/xcorr_peak_finder.sv
// Per-frame windowed peak search over cross-spectrum bin powers; optional macro XCORR_PEAK_NEIGHBOURS_EN adds peak-1/peak+1 values.
// Latency: result valid 1 cycle after the s_last handshake.
// Backpressure: s_ready drops while a result waits for m_ready, plus a 1-cycle bubble per frame.
module xcorr_peak_finder #(
  parameter int DATA_W  = 47,
  parameter int BIN_W   = 10,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 511
) (
  input logic                clk,
  input logic                reset_b,
  xcorr_peak_finder_if.slave bus
);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t            state, state_nxt;
  logic              s_ready_c, m_valid_c;
  logic              accept, last_beat, clear_frame, in_win, take;

  // Running per-frame search state
  logic [BIN_W-1:0]  bin_cnt;
  logic              cnt_full;   // all 2^BIN_W bin indices have been used
  logic [DATA_W-1:0] max_val;
  logic [BIN_W-1:0]  max_bin;
  logic              seen;       // an in-window beat has been seen this frame
  logic              len_err;

  logic [DATA_W-1:0] max_nxt;
  logic [BIN_W-1:0]  bin_nxt;
  logic              seen_nxt, err_nxt;

  // Registered frame result
  logic [DATA_W-1:0] peak_value_q;
  logic [BIN_W-1:0]  peak_bin_q;
  logic              no_peak_q, len_err_q;

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= SCAN;
    else          state <= state_nxt;
  end

  // Next state and stream handshake outputs
  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    case (state)
      SCAN: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && bus.s_last) state_nxt = HOLD;
      end
      HOLD: begin
        m_valid_c = 1'b1;
        if (bus.m_ready) state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  assign accept      = s_ready_c && bus.s_valid;
  assign last_beat   = accept && bus.s_last;
  assign clear_frame = m_valid_c && bus.m_ready;
  assign in_win      = (bin_cnt >= BIN_W'(MIN_BIN)) && (bin_cnt <= BIN_W'(MAX_BIN));

  // Search state as it stands once the current beat is folded in; ties keep the earlier bin
  always_comb begin
    take     = accept && in_win && (!seen || (bus.s_data > max_val));
    max_nxt  = take ? bus.s_data : max_val;
    bin_nxt  = take ? bin_cnt : max_bin;
    seen_nxt = seen || (accept && in_win);
    err_nxt  = len_err || (accept && cnt_full);
  end

  // Bin counter and running max, cleared at reset and when a result is consumed
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bin_cnt  <= '0;
      cnt_full <= 1'b0;
      max_val  <= '0;
      max_bin  <= '0;
      seen     <= 1'b0;
      len_err  <= 1'b0;
    end else if (clear_frame) begin
      bin_cnt  <= '0;
      cnt_full <= 1'b0;
      max_val  <= '0;
      max_bin  <= '0;
      seen     <= 1'b0;
      len_err  <= 1'b0;
    end else if (accept) begin
      if (bin_cnt == '1) cnt_full <= 1'b1;
      else               bin_cnt  <= bin_cnt + BIN_W'(1);
      max_val <= max_nxt;
      max_bin <= bin_nxt;
      seen    <= seen_nxt;
      len_err <= err_nxt;
    end
  end

  // Frame result capture on the last beat; held until the next frame ends
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      peak_value_q <= '0;
      peak_bin_q   <= '0;
      no_peak_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else if (last_beat) begin
      peak_value_q <= seen_nxt ? max_nxt : '0;
      peak_bin_q   <= seen_nxt ? bin_nxt : '0;
      no_peak_q    <= !seen_nxt;
      len_err_q    <= err_nxt;
    end
  end

  assign bus.s_ready      = s_ready_c;
  assign bus.m_valid      = m_valid_c;
  assign bus.m_peak_value = peak_value_q;
  assign bus.m_peak_bin   = peak_bin_q;
  assign bus.m_no_peak    = no_peak_q;
  assign bus.m_len_err    = len_err_q;

`ifdef XCORR_PEAK_NEIGHBOURS_EN
  logic [DATA_W-1:0] prev_val, left_val, right_val, left_nxt, right_nxt;
  logic [DATA_W-1:0] left_q, right_q;
  logic              right_pend;

  // Neighbours follow the beat order regardless of window: left from the previous beat, right from the next
  always_comb begin
    left_nxt  = take ? prev_val : left_val;
    right_nxt = take ? '0 : ((accept && right_pend) ? bus.s_data : right_val);
  end

  // Neighbour tracking, cleared at frame start
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      prev_val   <= '0;
      left_val   <= '0;
      right_val  <= '0;
      right_pend <= 1'b0;
    end else if (clear_frame) begin
      prev_val   <= '0;
      left_val   <= '0;
      right_val  <= '0;
      right_pend <= 1'b0;
    end else if (accept) begin
      prev_val   <= bus.s_data;
      left_val   <= left_nxt;
      right_val  <= right_nxt;
      right_pend <= take;
    end
  end

  // Neighbour result capture alongside the peak
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      left_q  <= '0;
      right_q <= '0;
    end else if (last_beat) begin
      left_q  <= left_nxt;
      right_q <= right_nxt;
    end
  end

  assign bus.m_left_value  = left_q;
  assign bus.m_right_value = right_q;
`endif

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Bench for xcorr_peak_finder: directed and random frames checked against a per-frame reference model.
// Frames are held in a queue; the model scans the whole frame with plain array arithmetic.
`timescale 1ns/1ps
module tb_xcorr_peak_finder;

  localparam int DATA_W  = 47;
  localparam int BIN_W   = 10;
  localparam int MIN_BIN = 1;
  localparam int MAX_BIN = 511;
  localparam int NBINS   = 1 << BIN_W;

  typedef logic [DATA_W-1:0] val_t;
  typedef struct packed {
    val_t             value;
    logic [BIN_W-1:0] bin;
    logic             no_peak;
    logic             len_err;
    val_t             left;
    val_t             right;
  } exp_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  val_t frame[$];

  xcorr_peak_finder_if #(.DATA_W(DATA_W), .BIN_W(BIN_W)) bus();

  xcorr_peak_finder #(
    .DATA_W(DATA_W), .BIN_W(BIN_W), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole-frame reference: beat i sits in bin min(i, NBINS-1); strict greater wins, so the first max is kept
  function automatic exp_t model();
    exp_t e;
    int   best;
    e    = '0;
    best = -1;
    for (int i = 0; i < frame.size(); i++) begin
      int b;
      b = (i < NBINS) ? i : NBINS - 1;
      if (b >= MIN_BIN && b <= MAX_BIN && (best < 0 || frame[i] > frame[best])) best = i;
    end
    e.len_err = (frame.size() > NBINS);
    if (best < 0) begin
      e.no_peak = 1'b1;
    end else begin
      e.value = frame[best];
      e.bin   = BIN_W'((best < NBINS) ? best : NBINS - 1);
      e.left  = (best > 0) ? frame[best-1] : '0;
      e.right = (best + 1 < frame.size()) ? frame[best+1] : '0;
    end
    return e;
  endfunction

  task automatic fill(input int n, input val_t v);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(v);
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!bus.s_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.s_ready) check_eq("s_ready_timeout", 64'd0, 64'd1);
  endtask

  // Drive the first n beats of the frame, with random idle gaps; s_last only if end_frame
  task automatic send_beats(input int n, input int gap_pct, input bit end_frame);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = frame[i];
      bus.s_last  = end_frame && (i == n - 1);
      wait_ready();
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic collect(input exp_t e, input int stall);
    check_eq("m_valid_latency", 64'(bus.m_valid), 64'd1);
    check_eq("peak_value", 64'(bus.m_peak_value), 64'(e.value));
    check_eq("peak_bin", 64'(bus.m_peak_bin), 64'(e.bin));
    check_eq("no_peak", 64'(bus.m_no_peak), 64'(e.no_peak));
    check_eq("len_err", 64'(bus.m_len_err), 64'(e.len_err));
`ifdef XCORR_PEAK_NEIGHBOURS_EN
    check_eq("left_value", 64'(bus.m_left_value), 64'(e.left));
    check_eq("right_value", 64'(bus.m_right_value), 64'(e.right));
`endif
    for (int c = 0; c < stall; c++) begin
      @(posedge clk); #1;
      check_eq("hold_s_ready", 64'(bus.s_ready), 64'd0);
      check_eq("hold_m_valid", 64'(bus.m_valid), 64'd1);
      check_eq("hold_value", 64'(bus.m_peak_value), 64'(e.value));
      check_eq("hold_bin", 64'(bus.m_peak_bin), 64'(e.bin));
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    check_eq("done_m_valid", 64'(bus.m_valid), 64'd0);
    check_eq("done_s_ready", 64'(bus.s_ready), 64'd1);
    check_eq("done_value_held", 64'(bus.m_peak_value), 64'(e.value));
  endtask

  task automatic run(input int gap_pct, input int stall);
    exp_t e;
    e = model();
    send_beats(frame.size(), gap_pct, 1'b1);
    collect(e, stall);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
    check_eq({tag, "_s_ready"}, 64'(bus.s_ready), 64'd1);
    check_eq({tag, "_value"}, 64'(bus.m_peak_value), 64'd0);
    check_eq({tag, "_bin"}, 64'(bus.m_peak_bin), 64'd0);
    check_eq({tag, "_no_peak"}, 64'(bus.m_no_peak), 64'd0);
    check_eq({tag, "_len_err"}, 64'(bus.m_len_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    reset_b = 1'b1;
    @(posedge clk); #1;

    // Basic peak
    fill(1024, 47'd5);
    frame[300] = 47'd1000;
    run(0, 0);

    // Out-of-window giants ignored, tie keeps the lower bin
    fill(1024, 47'd1);
    frame[0] = 47'd9999; frame[600] = 47'd9999;
    frame[20] = 47'd77;  frame[40] = 47'd77;
    run(0, 0);

    // Backpressure then a second frame after the bubble
    fill(64, 47'd1);
    frame[10] = 47'd50;
    run(0, 5);
    fill(64, 47'd1);
    frame[12] = 47'd60;
    run(0, 0);

    // Single-beat frame holds only bin 0
    fill(1, 47'd12345);
    run(0, 0);

    // Over-length frame
    frame.delete();
    for (int i = 0; i < 1030; i++) frame.push_back(val_t'({$urandom, $urandom}));
    run(0, 0);

    // Random frames with gaps, some tie-heavy
    for (int f = 0; f < 6; f++) begin
      int n;
      bit narrow;
      n      = $urandom_range(1, 1040);
      narrow = $urandom_range(1);
      frame.delete();
      for (int i = 0; i < n; i++)
        frame.push_back(narrow ? val_t'($urandom_range(7)) : val_t'({$urandom, $urandom}));
      run(30, $urandom_range(3));
    end

`ifdef XCORR_PEAK_NEIGHBOURS_EN
    fill(256, 47'd1);
    frame[99] = 47'd30; frame[100] = 47'd90; frame[101] = 47'd40;
    run(0, 0);
    fill(512, 47'd1);
    frame[511] = 47'd500;
    run(0, 0);
`endif

    // Reset at beat 200 of a frame carrying a huge value, then a clean frame
    fill(1024, 47'd3);
    frame[50] = {DATA_W{1'b1}};
    send_beats(200, 0, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = frame[200];
    reset_b     = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.s_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_b = 1'b1;
    frame.delete();
    for (int i = 0; i < 1024; i++) frame.push_back(val_t'($urandom_range(1000)));
    run(10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xcorr_peak_finder.md
Name: xcorr_peak_finder

Overview:
- Consumer side of the cross-spectrum multiplier output stream. Takes one 47-bit per-bin power value per beat over a valid/ready stream, framed by s_last.
- Over each FFT frame, finds the largest value inside a configurable bin window and its bin index.
- Presents one result per frame on a valid/ready output for the downstream bearing/TDOA logic.

Parameters:
- DATA_W, 47, width of incoming per-bin power value; treated as unsigned
- BIN_W, 10, bin index width; 1024-point FFT
- MIN_BIN, 1, lowest bin considered; 1 skips DC
- MAX_BIN, 511, highest bin considered; inclusive, positive-frequency half

Ports:
- clk  in  1  clock
- reset_b  in  1  reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  per-bin power value
- s_last  in  1  last beat of frame
- m_valid  out  1  frame result valid
- m_ready  in  1  result consumed when m_valid && m_ready
- m_peak_value  out  DATA_W  maximum in-window value
- m_peak_bin  out  BIN_W  bin index of maximum
- m_no_peak  out  1  frame contained no in-window bin
- m_len_err  out  1  frame longer than 2^BIN_W beats

Behaviour:
- Reset: reset_b is asynchronous, active-low; clock is clk.
  - Reset state: state=SCAN, s_ready=1, m_valid=0, all m_* data outputs 0.
  - Reset also clears the bin counter, running max, and the first-in-window flag.
  - Reset mid-frame discards the partial frame. The next accepted beat is bin 0.
- States: SCAN, HOLD.
- SCAN:
  - s_ready=1, m_valid=0.
  - Each accepted beat has bin index = bin counter, starting at 0. The counter increments per accepted beat.
  - The counter saturates at 2^BIN_W-1. An accepted beat while the counter is saturated sets the sticky len_err for this frame.
  - In-window beat means MIN_BIN <= bin <= MAX_BIN:
    - The first in-window beat loads the running max and its bin.
    - Later in-window beats replace the max only if s_data > max, unsigned strict compare. Ties keep the lower bin.
  - Out-of-window beats are accepted and counted but never compared.
  - Accepted beat with s_last=1:
    - The final beat is included in the compare.
    - Results are registered and the block enters HOLD.
    - m_valid=1 on the next cycle; latency is 1 cycle from the s_last handshake.
    - If no in-window beat was seen: m_no_peak=1, m_peak_value=0, m_peak_bin=0.
  - A single-beat frame (s_last on bin 0) is legal.
- HOLD:
  - s_ready=0. m_* outputs stay stable while m_valid=1 and m_ready=0.
  - On m_ready=1: return to SCAN next cycle with m_valid=0. Bin counter, max and flags are cleared.
  - s_ready=1 in that same next cycle. There is a 1-cycle input bubble per frame.
- m_* data outputs hold their last values after the handshake until the next frame result.
- s_valid=0 in SCAN: no state change. Gaps inside a frame are allowed.

Optional Feature:
- Macro: XCORR_PEAK_NEIGHBOURS_EN.
- With the macro defined, extra ports are added for parabolic sub-bin interpolation:
  - m_left_value  out  DATA_W: value of bin peak-1.
  - m_right_value  out  DATA_W: value of bin peak+1.
- Left neighbour:
  - A register holds the previous accepted beat's value. It is cleared to 0 at frame start.
  - On each max update, left is loaded from that register. Left=0 when the peak is bin 0.
- Right neighbour:
  - A max update sets a pending flag. The next accepted beat loads right and clears the flag.
  - If the peak is the last beat of the frame, right=0.
  - Neighbours are taken regardless of the bin window.
- Both extra outputs reset to 0 and follow the same hold rules as the other m_* outputs.
- Without the macro: the ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Basic peak: 1024-beat frame, all values 5, bin 300 = 1000, m_ready=1 → m_peak_value=1000, m_peak_bin=300, m_no_peak=0, m_len_err=0, m_valid 1 cycle after s_last.
- Window and tie: bin 0=9999, bin 600=9999 (outside window), bins 20 and 40 = 77 (in window, rest 1) → peak 77 at bin 20.
- Backpressure and bubble:
  - Frame 1 peak 50@bin 10, m_ready held 0 for 5 cycles → s_ready=0, outputs stable throughout.
  - Then m_ready=1 → s_ready=1 the next cycle.
  - Frame 2 peak 60@bin 12 is reported correctly.
- Boundaries:
  - Single-beat frame (bin 0, s_last) → m_no_peak=1, value 0, bin 0.
  - 1030-beat frame → m_len_err=1.
  - Random s_valid gaps do not change results.
- Reset mid-frame: assert reset_b=0 at beat 200 of a frame → all outputs 0. A fresh 1024-beat frame then reports its own peak with no residue from the aborted frame.
- XCORR_PEAK_NEIGHBOURS_EN:
  - Bins 99/100/101 = 30/90/40 → left=30, right=40.
  - Peak on the final beat (bin 511 of a 512-beat frame) → right=0.
